// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one add/sub/cmp ALU among NREQ requesters.
// Optional watchdog on the ALU wait is enabled by defining ALU_WDOG_EN.
module alu_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 4,
  parameter int IDW     = $clog2(NREQ),
  parameter int TIMEOUT = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NREQ-1:0]       i_req_valid,
  output logic [NREQ-1:0]       o_req_ready,
  input  logic [NREQ*WIDTH-1:0] i_req_op1,
  input  logic [NREQ*WIDTH-1:0] i_req_op2,
  input  logic [NREQ*2-1:0]     i_req_opc,
  output logic [WIDTH-1:0]      o_alu_op1,
  output logic [WIDTH-1:0]      o_alu_op2,
  output logic                  o_alu_add,
  output logic                  o_alu_sub,
  output logic                  o_alu_cmp,
  output logic                  o_alu_start,
  input  logic [WIDTH:0]        i_alu_result,
  input  logic                  i_alu_done,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [IDW-1:0]        o_rsp_id,
  output logic [WIDTH:0]        o_rsp_result,
  output logic                  o_rsp_eq,
  output logic                  o_rsp_lt,
  output logic                  o_rsp_err
);

  if (NREQ < 2 || NREQ > 8 || IDW != $clog2(NREQ) || TIMEOUT < 1) begin : g_cfg_check
    $error("alu_share_arbiter: unsupported NREQ/IDW/TIMEOUT combination");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Compare flags only mean something for cmp; add/sub report zero flags.
  function automatic logic [1:0] cmp_flags(input logic [WIDTH:0] res, input logic is_cmp);
    logic [1:0] flags;
    flags = 2'b00;
    if (is_cmp) begin
      flags = {(res[WIDTH-1:0] == '0), res[WIDTH]};
    end
    return flags;
  endfunction

  state_t             r_state;
  logic [IDW-1:0]     r_rr_ptr;
  logic [IDW-1:0]     r_id;
  logic [WIDTH-1:0]   r_alu_op1;
  logic [WIDTH-1:0]   r_alu_op2;
  logic               r_alu_add;
  logic               r_alu_sub;
  logic               r_alu_cmp;
  logic               r_alu_start;
  logic               r_rsp_valid;
  logic [IDW-1:0]     r_rsp_id;
  logic [WIDTH:0]     r_rsp_result;
  logic               r_rsp_eq;
  logic               r_rsp_lt;
  logic               r_rsp_err;

  logic               w_gnt_found;
  logic [IDW-1:0]     w_gnt_id;
  logic [NREQ-1:0]    w_gnt_onehot;
  logic               w_accept;
  logic [IDW-1:0]     w_next_ptr;
  logic [WIDTH-1:0]   w_gnt_op1;
  logic [WIDTH-1:0]   w_gnt_op2;
  logic [1:0]         w_gnt_opc;

`ifdef ALU_WDOG_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0]     r_wdog;
`endif

  // Scan from the highest offset down so the nearest valid at/after rr_ptr wins.
  always_comb begin
    logic [IDW-1:0] idx;
    w_gnt_found  = 1'b0;
    w_gnt_id     = '0;
    w_gnt_onehot = '0;
    idx          = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(r_rr_ptr) + k) % NREQ);
      if (i_req_valid[idx]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = idx;
      end
    end
    if (w_gnt_found) begin
      w_gnt_onehot[w_gnt_id] = 1'b1;
    end
  end

  assign w_accept    = (r_state == S_IDLE) && w_gnt_found;
  assign o_req_ready = (r_state == S_IDLE && i_rst_n) ? w_gnt_onehot : '0;
  assign w_next_ptr  = (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + IDW'(1);
  assign w_gnt_op1   = i_req_op1[w_gnt_id*WIDTH +: WIDTH];
  assign w_gnt_op2   = i_req_op2[w_gnt_id*WIDTH +: WIDTH];
  assign w_gnt_opc   = i_req_opc[w_gnt_id*2 +: 2];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_id         <= '0;
      r_alu_op1    <= '0;
      r_alu_op2    <= '0;
      r_alu_add    <= 1'b0;
      r_alu_sub    <= 1'b0;
      r_alu_cmp    <= 1'b0;
      r_alu_start  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
      r_rsp_eq     <= 1'b0;
      r_rsp_lt     <= 1'b0;
      r_rsp_err    <= 1'b0;
`ifdef ALU_WDOG_EN
      r_wdog       <= '0;
`endif
    end else begin
      r_alu_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rr_ptr <= w_next_ptr;
            if (w_gnt_opc == 2'b11) begin
              // Illegal opcode never touches the ALU; answer straight away.
              r_state      <= S_RESP;
              r_rsp_valid  <= 1'b1;
              r_rsp_id     <= w_gnt_id;
              r_rsp_result <= '0;
              r_rsp_eq     <= 1'b0;
              r_rsp_lt     <= 1'b0;
              r_rsp_err    <= 1'b1;
            end else begin
              r_state     <= S_ISSUE;
              r_id        <= w_gnt_id;
              r_alu_op1   <= w_gnt_op1;
              r_alu_op2   <= w_gnt_op2;
              r_alu_add   <= (w_gnt_opc == 2'b00);
              r_alu_sub   <= (w_gnt_opc == 2'b01);
              r_alu_cmp   <= (w_gnt_opc == 2'b10);
              r_alu_start <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
`ifdef ALU_WDOG_EN
          r_wdog  <= '0;
`endif
        end
        S_WAIT: begin
          if (i_alu_done) begin
            r_state                <= S_RESP;
            r_rsp_valid            <= 1'b1;
            r_rsp_id               <= r_id;
            r_rsp_result           <= i_alu_result;
            {r_rsp_eq, r_rsp_lt}   <= cmp_flags(i_alu_result, r_alu_cmp);
            r_rsp_err              <= 1'b0;
            r_alu_op1              <= '0;
            r_alu_op2              <= '0;
            r_alu_add              <= 1'b0;
            r_alu_sub              <= 1'b0;
            r_alu_cmp              <= 1'b0;
          end
`ifdef ALU_WDOG_EN
          else if (r_wdog == WDW'(TIMEOUT - 1)) begin
            r_state      <= S_RESP;
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= r_id;
            r_rsp_result <= '0;
            r_rsp_eq     <= 1'b0;
            r_rsp_lt     <= 1'b0;
            r_rsp_err    <= 1'b1;
            r_alu_op1    <= '0;
            r_alu_op2    <= '0;
            r_alu_add    <= 1'b0;
            r_alu_sub    <= 1'b0;
            r_alu_cmp    <= 1'b0;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_alu_op1    = r_alu_op1;
  assign o_alu_op2    = r_alu_op2;
  assign o_alu_add    = r_alu_add;
  assign o_alu_sub    = r_alu_sub;
  assign o_alu_cmp    = r_alu_cmp;
  assign o_alu_start  = r_alu_start;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_id     = r_rsp_id;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_eq     = r_rsp_eq;
  assign o_rsp_lt     = r_rsp_lt;
  assign o_rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: handshake timing, cmp flags, fairness,
// backpressure, illegal opcode, reset mid-operation and the ALU_WDOG_EN watchdog.
module tb_alu_share_arbiter;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_op1;
  logic [N*W-1:0] req_op2;
  logic [2*N-1:0] req_opc;
  logic [W-1:0]   alu_op1;
  logic [W-1:0]   alu_op2;
  logic           alu_add;
  logic           alu_sub;
  logic           alu_cmp;
  logic           alu_start;
  logic [W:0]     alu_result;
  logic           alu_done;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [W:0]     rsp_result;
  logic           rsp_eq;
  logic           rsp_lt;
  logic           rsp_err;

  int n_checks = 0;
  int n_fail   = 0;
  bit alu_en   = 1'b0;
  int alu_lat  = 1;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IW), .TIMEOUT(64)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_op1(req_op1), .i_req_op2(req_op2), .i_req_opc(req_opc),
    .o_alu_op1(alu_op1), .o_alu_op2(alu_op2),
    .o_alu_add(alu_add), .o_alu_sub(alu_sub), .o_alu_cmp(alu_cmp),
    .o_alu_start(alu_start), .i_alu_result(alu_result), .i_alu_done(alu_done),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
    .o_rsp_result(rsp_result), .o_rsp_eq(rsp_eq), .o_rsp_lt(rsp_lt), .o_rsp_err(rsp_err)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] opc);
    req_op1[id*W +: W] = a;
    req_op2[id*W +: W] = b;
    req_opc[id*2 +: 2] = opc;
  endtask

  // Issue one request and return on the first cycle rsp_valid is seen.
  task automatic run_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] opc, input logic [N-1:0] others,
                        output bit saw_start);
    bit ok;
    set_req(id, a, b, opc);
    req_valid = others | (N'(1) << id);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (req_ready[id]) ok = 1'b1;
      else tick();
    end
    check("grant_wait", {63'd0, ok}, 64'd1);
    tick();
    req_valid = others;
    saw_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (alu_start) saw_start = 1'b1;
      if (rsp_valid) ok = 1'b1;
      else tick();
    end
    check("rsp_wait", {63'd0, ok}, 64'd1);
  endtask

  // Behavioural ALU: answers alu_start alu_lat cycles later with op1+op2 or op1-op2.
  initial begin
    logic [W:0] res;
    forever begin
      @(negedge clk);
      if (alu_en) alu_done = 1'b0;
      if (alu_en && alu_start) begin
        res = alu_add ? ({1'b0, alu_op1} + {1'b0, alu_op2}) : ({1'b0, alu_op1} - {1'b0, alu_op2});
        repeat (alu_lat) @(negedge clk);
        alu_result = res;
        alu_done   = 1'b1;
      end
    end
  end

  initial begin
    bit         st;
    int         n;
    int         cyc;
    logic [IW-1:0] ids [8];
    logic [W:0]    ress [8];

    rst_n      = 1'b0;
    req_valid  = 4'hF;
    req_op1    = '0;
    req_op2    = '0;
    req_opc    = '0;
    alu_result = '0;
    alu_done   = 1'b0;
    rsp_ready  = 1'b1;
    alu_en     = 1'b1;
    alu_lat    = 1;
    for (int i = 0; i < N; i++) set_req(i, 32'h10 * i, i, 2'b00);
    set_req(0, 32'hFFFF_FFFF, 32'h1, 2'b00);
    repeat (3) tick();
    #1;
    check("rst_req_ready", req_ready, 4'b0000);
    check("rst_alu_start", alu_start, 1'b0);
    check("rst_alu_add", {alu_add, alu_sub, alu_cmp}, 3'b000);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id", rsp_id, 2'd0);
    check("rst_rsp_result", rsp_result, 33'd0);

    // Release with all four valid: requester 0 must win.
    rst_n = 1'b1;
    #1;
    check("first_grant", req_ready, 4'b0001);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    check("add_c1_start", alu_start, 1'b1);
    check("add_c1_sel", {alu_add, alu_sub, alu_cmp}, 3'b100);
    check("add_c1_op1", alu_op1, 32'hFFFF_FFFF);
    check("add_c1_op2", alu_op2, 32'h1);
    check("add_c1_no_ready", req_ready, 4'b0000);
    tick();
    check("add_c2_start", alu_start, 1'b0);
    check("add_c2_hold", alu_add, 1'b1);
    check("add_c2_rsp", rsp_valid, 1'b0);
    tick();
    check("add_c3_rsp_valid", rsp_valid, 1'b1);
    check("add_c3_id", rsp_id, 2'd0);
    check("add_c3_result", rsp_result, 33'h1_0000_0000);
    check("add_c3_flags", {rsp_eq, rsp_lt, rsp_err}, 3'b000);
    check("add_c3_alu_idle", {alu_add, alu_op1}, 33'd0);
    tick();
    check("add_c4_idle", rsp_valid, 1'b0);

    // Illegal opcode from requester 1.
    run_op(1, 32'h3, 32'h4, 2'b11, 4'b0000, st);
    check("ill_no_start", st, 1'b0);
    check("ill_err", rsp_err, 1'b1);
    check("ill_result", rsp_result, 33'd0);
    check("ill_id", rsp_id, 2'd1);
    tick();

    // cmp from requester 2: 5 vs 7, then 9 vs 9.
    run_op(2, 32'd5, 32'd7, 2'b10, 4'b0000, st);
    check("cmp_lt_start", st, 1'b1);
    check("cmp_lt_result", rsp_result, 33'h1_FFFF_FFFE);
    check("cmp_lt_flags", {rsp_eq, rsp_lt, rsp_err}, 3'b010);
    check("cmp_lt_id", rsp_id, 2'd2);
    tick();
    run_op(2, 32'd9, 32'd9, 2'b10, 4'b0000, st);
    check("cmp_eq_result", rsp_result, 33'd0);
    check("cmp_eq_flags", {rsp_eq, rsp_lt, rsp_err}, 3'b100);
    tick();

    // Backpressure on requester 3 while requester 0 waits behind it.
    rsp_ready = 1'b0;
    run_op(3, 32'd3, 32'd4, 2'b00, 4'b0001, st);
    check("bp_result", rsp_result, 33'd7);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid_hold", rsp_valid, 1'b1);
      check("bp_result_hold", rsp_result, 33'd7);
      check("bp_id_hold", rsp_id, 2'd3);
      check("bp_no_ready", req_ready, 4'b0000);
    end
    rsp_ready = 1'b1;
    tick();
    #1;
    check("bp_released", rsp_valid, 1'b0);
    check("bp_pending_grant", req_ready, 4'b0001);
    req_valid = 4'b0000;
    for (int i = 0; i < N; i++) set_req(i, 32'h10 * i, i, 2'b00);

    // Fairness with all four held valid.
    req_valid = 4'hF;
    n = 0;
    for (int c = 0; c < 100 && n < 8; c++) begin
      if (rsp_valid) begin
        ids[n]  = rsp_id;
        ress[n] = rsp_result;
        n++;
      end
      if (n < 8) tick();
    end
    req_valid = 4'h0;
    check("rr_count", n, 8);
    for (int k = 0; k < 8; k++) begin
      check("rr_id", ids[k], k % 4);
      check("rr_result", ress[k], 33'h11 * (k % 4));
    end
    tick();

    // Reset pulse in the middle of WAIT, then a late alu_done.
    alu_en = 1'b0;
    set_req(1, 32'd1, 32'd2, 2'b00);
    req_valid = 4'b0010;
    #1;
    check("rstw_grant", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0000;
    repeat (3) tick();
    check("rstw_in_wait", alu_add, 1'b1);
    rst_n = 1'b0;
    tick();
    check("rstw_alu_clear", {alu_start, alu_add, alu_op1}, 34'd0);
    check("rstw_rsp", rsp_valid, 1'b0);
    rst_n      = 1'b1;
    alu_done   = 1'b1;
    alu_result = 33'd3;
    tick();
    alu_done = 1'b0;
    check("rstw_late_done", rsp_valid, 1'b0);

    // Requester 2 add with a spurious done during ISSUE and no real done.
    set_req(2, 32'd4, 32'd5, 2'b00);
    req_valid = 4'b0100;
    #1;
    check("wd_grant", req_ready, 4'b0100);
    tick();
    req_valid  = 4'b0000;
    check("wd_issue", alu_start, 1'b1);
    alu_done   = 1'b1;
    alu_result = 33'h123;
    tick();
    alu_done = 1'b0;
    cyc = 1;
`ifdef ALU_WDOG_EN
    while (!rsp_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    check("wd_cycles", cyc, 65);
    check("wd_err", rsp_err, 1'b1);
    check("wd_result", rsp_result, 33'd0);
    check("wd_flags", {rsp_eq, rsp_lt}, 2'b00);
    check("wd_id", rsp_id, 2'd2);
`else
    repeat (80) begin
      tick();
      cyc++;
    end
    check("wait_persist", rsp_valid, 1'b0);
    check("wait_hold_add", alu_add, 1'b1);
    alu_done   = 1'b1;
    alu_result = 33'd9;
    tick();
    alu_done = 1'b0;
    check("late_rsp_valid", rsp_valid, 1'b1);
    check("late_rsp_result", rsp_result, 33'd9);
    check("late_rsp_err", rsp_err, 1'b0);
    check("late_rsp_id", rsp_id, 2'd2);
`endif
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
